parking_sensor_gen: RTL and testbench

Sensor-pair stimulus generator for the parking-lot occupancy path. On an enter or exit request it drives the A/B photo-sensor pair through the full four-phase crossing sequence, with a programmable hold time per phase. It keeps a shadow occupancy count and refuses requests that would overflow or underflow the lot. It is the transmitter-side counterpart to the sensor FSM and counter. It drives their `A`/`B` inputs in benches and on-board demos in place of the push-button `KEY` inputs.

---
 rtl/parking_sensor_gen_if.sv | 26 ++
 rtl/parking_sensor_gen.sv | 135 +++++++++++++
 tb/tb_parking_sensor_gen.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/parking_sensor_gen_if.sv
// Request/status bundle between a crossing-sequence requester (master) and parking_sensor_gen (slave).
// Requests are level inputs that are sampled only while the generator is idle. Status outputs are registered.
interface parking_sensor_gen_if #(
  parameter int DWELL_W = 8
);
  logic               start_enter;
  logic               start_exit;
  logic [DWELL_W-1:0] dwell;
  logic               balk;
  logic               A;
  logic               B;
  logic               busy;
  logic               done;
  logic               reject;
  logic [4:0]         occ;

  modport master (
    output start_enter, start_exit, dwell, balk,
    input  A, B, busy, done, reject, occ
  );

  modport slave (
    input  start_enter, start_exit, dwell, balk,
    output A, B, busy, done, reject, occ
  );
endinterface

// File: rtl/parking_sensor_gen.sv
// Drives the A/B photo-sensor pair through a four-phase car crossing. The request is sampled in IDLE, PH1 shows on the next cycle, and each phase lasts dwell+1 cycles.
// Requests are ignored while busy. Requests that would overflow or underflow occ get a one-cycle reject. Balk/REV support is enabled by `PARKING_SENSOR_GEN_BALK_EN.
module parking_sensor_gen #(
  parameter int DWELL_W  = 8,
  parameter int CAPACITY = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  parking_sensor_gen_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE, PH1, PH2, PH3, GAP
`ifdef PARKING_SENSOR_GEN_BALK_EN
    , REV
`endif
  } state_t;

  localparam logic [4:0] OCC_MAX = 5'(CAPACITY);

  state_t             state;
  logic               dir_enter;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] cnt;
`ifdef PARKING_SENSOR_GEN_BALK_EN
  logic               balked;
`else
  logic               unused_balk;
  assign unused_balk = bus.balk;
`endif

  // Sensor pattern for a phase. An exit mirrors an entry, and REV replays PH1 while the car backs out.
  function automatic logic [1:0] phase_ab(input state_t s, input logic ent);
    logic [1:0] v;
    case (s)
      PH1:     v = ent ? 2'b10 : 2'b01;
      PH2:     v = 2'b11;
      PH3:     v = ent ? 2'b01 : 2'b10;
`ifdef PARKING_SENSOR_GEN_BALK_EN
      REV:     v = ent ? 2'b10 : 2'b01;
`endif
      default: v = 2'b00;
    endcase
    return v;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      dir_enter    <= 1'b0;
      dwell_q      <= '0;
      cnt          <= '0;
      bus.A        <= 1'b0;
      bus.B        <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.reject   <= 1'b0;
      bus.occ      <= 5'd0;
`ifdef PARKING_SENSOR_GEN_BALK_EN
      balked       <= 1'b0;
`endif
    end else begin
      bus.done   <= 1'b0;
      bus.reject <= 1'b0;
      if (state == IDLE) begin
        if (bus.start_enter && bus.start_exit) begin
          bus.reject <= 1'b1;
        end else if (bus.start_enter || bus.start_exit) begin
          if (bus.start_enter ? (bus.occ < OCC_MAX) : (bus.occ != 5'd0)) begin
            state          <= PH1;
            dir_enter      <= bus.start_enter;
            dwell_q        <= bus.dwell;
            cnt            <= bus.dwell;
            bus.busy       <= 1'b1;
            {bus.A, bus.B} <= phase_ab(PH1, bus.start_enter);
`ifdef PARKING_SENSOR_GEN_BALK_EN
            balked         <= 1'b0;
`endif
          end else begin
            bus.reject <= 1'b1;
          end
        end
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else begin
        cnt <= dwell_q;
        case (state)
          PH1: begin
            state          <= PH2;
            {bus.A, bus.B} <= phase_ab(PH2, dir_enter);
          end
          PH2: begin
`ifdef PARKING_SENSOR_GEN_BALK_EN
            if (bus.balk) begin
              state          <= REV;
              balked         <= 1'b1;
              {bus.A, bus.B} <= phase_ab(REV, dir_enter);
            end else
`endif
            begin
              state          <= PH3;
              {bus.A, bus.B} <= phase_ab(PH3, dir_enter);
            end
          end
`ifdef PARKING_SENSOR_GEN_BALK_EN
          REV: begin
            state          <= GAP;
            {bus.A, bus.B} <= 2'b00;
          end
`endif
          PH3: begin
            state          <= GAP;
            {bus.A, bus.B} <= 2'b00;
          end
          GAP: begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            // A balked car never crossed, so the count stays unchanged.
`ifdef PARKING_SENSOR_GEN_BALK_EN
            if (!balked)
`endif
              bus.occ <= dir_enter ? bus.occ + 5'd1 : bus.occ - 5'd1;
          end
          default: begin
            state          <= IDLE;
            bus.busy       <= 1'b0;
            {bus.A, bus.B} <= 2'b00;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parking_sensor_gen.sv
// Scoreboard bench for parking_sensor_gen: a reference model queues the expected per-cycle outputs, and a monitor compares them.
module tb_parking_sensor_gen;
  localparam int CAP = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  parking_sensor_gen_if #(.DWELL_W(8)) bus ();
  parking_sensor_gen #(.DWELL_W(8), .CAPACITY(CAP)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic       busy;
    logic [1:0] ab;
    logic       done;
    logic       rej;
    logic [4:0] occ;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_o, mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_occ    = 0;
  int   rem      = 0;
  int   bk_rem   = -1;
  logic plan_balk = 1'b0;
  logic cur_plan  = 1'b0;
  bit   mon_en    = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
  endtask

  function automatic obs_t mk(input logic busy, input logic [1:0] ab, input logic done,
                              input logic rej, input int occ);
    obs_t o;
    o.busy = busy; o.ab = ab; o.done = done; o.rej = rej; o.occ = 5'(occ);
    return o;
  endfunction

  // Reference model of one accepted crossing: four phases of d+1 cycles each, then a done cycle.
  task automatic accept(input logic ent, input logic [7:0] d);
    logic [1:0] ph [4];
    bit balked;
    int nocc;
    ph[0] = ent ? 2'b10 : 2'b01;
    ph[1] = 2'b11;
    ph[2] = ent ? 2'b01 : 2'b10;
    ph[3] = 2'b00;
    balked = 1'b0;
`ifdef PARKING_SENSOR_GEN_BALK_EN
    balked = plan_balk;
    if (balked) ph[2] = ph[0];
`endif
    cur_plan = plan_balk;
    for (int p = 0; p < 4; p++)
      for (int c = 0; c <= int'(d); c++)
        exp_q.push_back(mk(1'b1, ph[p], 1'b0, 1'b0, m_occ));
    nocc = balked ? m_occ : (ent ? m_occ + 1 : m_occ - 1);
    exp_q.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, nocc));
    m_occ  = nocc;
    rem    = 4 * (int'(d) + 1);
    bk_rem = 2 * int'(d) + 3;
  endtask

  task automatic drive(input logic se, input logic sx, input logic [7:0] d, input logic bk);
    @(negedge clk);
    bus.start_enter = se;
    bus.start_exit  = sx;
    bus.dwell       = d;
    bus.balk        = (rem == bk_rem) ? cur_plan : bk;
    if (rem == 0) begin
      if (se && sx) exp_q.push_back(mk(1'b0, 2'b00, 1'b0, 1'b1, m_occ));
      else if (se) begin
        if (m_occ < CAP) accept(1'b1, d);
        else exp_q.push_back(mk(1'b0, 2'b00, 1'b0, 1'b1, m_occ));
      end else if (sx) begin
        if (m_occ > 0) accept(1'b0, d);
        else exp_q.push_back(mk(1'b0, 2'b00, 1'b0, 1'b1, m_occ));
      end
    end else begin
      rem--;
    end
    @(posedge clk);
  endtask

  task automatic finish_seq(input bit noisy);
    while (rem > 0)
      drive(noisy & 1'($urandom_range(0, 1)), noisy & 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
  endtask

  task automatic set_occ(input int target);
    while (m_occ != target) begin
      drive(m_occ < target, m_occ > target, 8'd0, 1'b0);
      finish_seq(1'b0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_o.busy = bus.busy;
      mon_o.ab   = {bus.A, bus.B};
      mon_o.done = bus.done;
      mon_o.rej  = bus.reject;
      mon_o.occ  = bus.occ;
      if (mon_o.busy || mon_o.done || mon_o.rej) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", 32'({mon_o.busy, mon_o.done, mon_o.rej}), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("trace", 32'(mon_o), 32'(mon_e));
        end
      end else begin
        check("idle_ab", 32'(mon_o.ab), 32'd0);
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.start_enter = 1'b0;
    bus.start_exit  = 1'b0;
    bus.dwell       = 8'd0;
    bus.balk        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ab",     32'({bus.A, bus.B}), 32'd0);
    check("rst_busy",   32'(bus.busy),       32'd0);
    check("rst_done",   32'(bus.done),       32'd0);
    check("rst_reject", 32'(bus.reject),     32'd0);
    check("rst_occ",    32'(bus.occ),        32'd0);
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;

    drive(1'b0, 1'b1, 8'd0, 1'b0);
    repeat (2) drive(1'b0, 1'b0, 8'd0, 1'b0);

    drive(1'b1, 1'b0, 8'd0, 1'b0);
    finish_seq(1'b0);
    drive(1'b0, 1'b0, 8'd0, 1'b0);

    while (m_occ < CAP) begin
      drive(1'b1, 1'b0, 8'd2, 1'b0);
      finish_seq(1'b1);
    end
    drive(1'b1, 1'b0, 8'd2, 1'b0);
    repeat (2) drive(1'b0, 1'b0, 8'd0, 1'b0);

    drive(1'b1, 1'b1, 8'd1, 1'b0);
    repeat (2) drive(1'b0, 1'b0, 8'd0, 1'b0);

    set_occ(2);
    plan_balk = 1'b1;
    drive(1'b1, 1'b0, 8'd1, 1'b0);
    finish_seq(1'b0);
    plan_balk = 1'b0;
    drive(1'b0, 1'b0, 8'd0, 1'b0);

    repeat (1500) begin
      plan_balk = 1'($urandom_range(0, 1));
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            8'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    plan_balk = 1'b0;
    finish_seq(1'b0);
    repeat (2) drive(1'b0, 1'b0, 8'd0, 1'b0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    set_occ(3);
    drive(1'b0, 1'b1, 8'd3, 1'b0);
    repeat (5) drive(1'b0, 1'b0, 8'd3, 1'b0);
    @(negedge clk);
    mon_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("midrst_ab",   32'({bus.A, bus.B}), 32'd0);
    check("midrst_occ",  32'(bus.occ),        32'd0);
    check("midrst_busy", 32'(bus.busy),       32'd0);
    exp_q.delete();
    rem   = 0;
    m_occ = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("post_rst_quiet", 32'({bus.busy, bus.done, bus.A, bus.B}), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
